mem_device_model: RTL

Cycle-accurate single-bank memory device that sits on the far side of the controller's command bus (command, RA, CA, DQ, cs_n). It decodes NOP/ACT/READ/WRITE/PRE/REFRESH, tracks the open row, stores data in a 2^(RA_W+CA_W)-word array and returns read data on DQ after a fixed CAS latency. It enforces tRCD/tWR/tRFC and refresh-interval rules, flags violations and ignores offending commands, so it serves as both the integration target and a protocol checker for the controller.

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_device_model_if.sv | 31 +++
 rtl/mem_rd_pipe.sv | 36 +++
 rtl/mem_device_model.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared command/error encodings and default timing for the memory device model.
// The controller imports the same cmd_t so both sides agree on opcodes.
package mem_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'b000,
    CMD_ACT     = 3'b001,
    CMD_READ    = 3'b010,
    CMD_WRITE   = 3'b011,
    CMD_PRE     = 3'b100,
    CMD_REFRESH = 3'b101,
    CMD_RSV6    = 3'b110,
    CMD_RSV7    = 3'b111
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_OPEN  = 3'd1,
    ERR_RW_CLOSED = 3'd2,
    ERR_RW_TRCD   = 3'd3,
    ERR_PRE_TWR   = 3'd4,
    ERR_REF_OPEN  = 3'd5,
    ERR_REF_BUSY  = 3'd6,
    ERR_ILLEGAL   = 3'd7
  } err_t;

  typedef enum logic [1:0] {
    ST_CLOSED,
    ST_ACTIVATING,
    ST_OPEN,
    ST_REFRESHING
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_RA_W      = 4;
  localparam int DEF_CA_W      = 12;
  localparam int DEF_CL        = 2;
  localparam int DEF_TRCD      = 5;
  localparam int DEF_TWR       = 4;
  localparam int DEF_TRFC      = 5;
  localparam int DEF_TREFI_MAX = 340;

endpackage

// File: rtl/mem_device_model_if.sv
// Command bus and status outputs between the controller (master) and the device (slave).
// DQ is bidirectional and stays a plain inout port on the device.
interface mem_device_model_if
  import mem_pkg::*;
#(
  parameter int RA_W = DEF_RA_W,
  parameter int CA_W = DEF_CA_W
);

  logic            cs_n;
  cmd_t            command;
  logic [RA_W-1:0] ra;
  logic [CA_W-1:0] ca;
  logic            rd_vld;
  logic            row_open;
  logic [RA_W-1:0] open_row;
  logic            err_vld;
  err_t            err_code;
  logic            refresh_overdue;

  modport master (
    output cs_n, command, ra, ca,
    input  rd_vld, row_open, open_row, err_vld, err_code, refresh_overdue
  );

  modport slave (
    input  cs_n, command, ra, ca,
    output rd_vld, row_open, open_row, err_vld, err_code, refresh_overdue
  );

endinterface

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read return path: a DEPTH-stage valid+data shift register.
// The last stage drives rd_vld and the data the top places on DQ.
module mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage samples its pre-edge neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= push_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/mem_device_model.sv
// Single-bank memory device: decodes the command bus, enforces tRCD/tWR/tRFC/tREFI,
// rejects and flags illegal commands, and returns read data on DQ after CL cycles.
module mem_device_model
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RA_W      = DEF_RA_W,
  parameter int CA_W      = DEF_CA_W,
  parameter int CL        = DEF_CL,
  parameter int TRCD      = DEF_TRCD,
  parameter int TWR       = DEF_TWR,
  parameter int TRFC      = DEF_TRFC,
  parameter int TREFI_MAX = DEF_TREFI_MAX
) (
  input  logic              clk,
  input  logic              rst,
  mem_device_model_if.slave bus,
  inout  wire [DATA_W-1:0]  dq
);

  localparam int AW     = RA_W + CA_W;
  localparam int CNT_W  = 8;
  localparam int REFI_W = $clog2(TREFI_MAX + 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  wr_rec_q;
  logic [REFI_W-1:0] refi_q;
  logic              row_open_q;
  logic [RA_W-1:0]   open_row_q;
  logic              err_vld_q;
  err_t              err_code_q;
  logic              overdue_q;
  logic [DATA_W-1:0] mem_q [2**AW];

  cmd_t              cmd;
  err_t              err;
  logic              accept, act_wait, ref_busy, is_open, is_closed;
  logic              rd_vld;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] rd_data, pipe_data;

  assign cmd  = bus.cs_n ? CMD_NOP : bus.command;
  assign addr = {open_row_q, bus.ca};

  // A countdown that has reached zero already behaves like the state it is heading to.
  assign act_wait  = (state_q == ST_ACTIVATING) && (cnt_q != '0);
  assign ref_busy  = (state_q == ST_REFRESHING) && (cnt_q != '0);
  assign is_open   = (state_q == ST_OPEN) || ((state_q == ST_ACTIVATING) && (cnt_q == '0));
  assign is_closed = (state_q == ST_CLOSED) || ((state_q == ST_REFRESHING) && (cnt_q == '0));

  always_comb begin
    // NOTE: err gets a default before the case so no path leaves it unassigned and no latch is inferred.
    err = ERR_NONE;
    case (cmd)
      CMD_NOP: ;
      CMD_ACT: begin
        if (act_wait || is_open) err = ERR_ACT_OPEN;
        else if (ref_busy)       err = ERR_REF_BUSY;
      end
      CMD_READ, CMD_WRITE: begin
        if (is_closed)                         err = ERR_RW_CLOSED;
        else if (act_wait)                     err = ERR_RW_TRCD;
        else if (ref_busy)                     err = ERR_REF_BUSY;
        else if (cmd == CMD_WRITE && rd_vld)   err = ERR_ILLEGAL;
      end
      CMD_PRE: begin
        if (is_open && wr_rec_q != '0) err = ERR_PRE_TWR;
        else if (ref_busy)             err = ERR_REF_BUSY;
      end
      CMD_REFRESH: begin
        if (act_wait || is_open) err = ERR_REF_OPEN;
        else if (ref_busy)       err = ERR_REF_BUSY;
      end
      default: err = ref_busy ? ERR_REF_BUSY : ERR_ILLEGAL;
    endcase
  end

  assign accept = (cmd != CMD_NOP) && (err == ERR_NONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLOSED;
      cnt_q      <= '0;
      wr_rec_q   <= '0;
      refi_q     <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      overdue_q  <= 1'b0;
    end else begin
      err_vld_q <= (err != ERR_NONE);
      if (err != ERR_NONE) err_code_q <= err;

      if (cnt_q != '0)    cnt_q    <= cnt_q - 1'b1;
      if (wr_rec_q != '0) wr_rec_q <= wr_rec_q - 1'b1;
      if (refi_q != REFI_W'(TREFI_MAX)) refi_q <= refi_q + 1'b1;
      if (refi_q >= REFI_W'(TREFI_MAX - 1)) overdue_q <= 1'b1;

      if (state_q == ST_ACTIVATING && cnt_q == '0) state_q <= ST_OPEN;
      if (state_q == ST_REFRESHING && cnt_q == '0) state_q <= ST_CLOSED;

      if (accept) begin
        case (cmd)
          CMD_ACT: begin
            state_q    <= ST_ACTIVATING;
            cnt_q      <= CNT_W'(TRCD - 1);
            row_open_q <= 1'b1;
            open_row_q <= bus.ra;
          end
          // Loaded one short so the counter reads zero exactly TWR cycles after the WRITE.
          CMD_WRITE: wr_rec_q <= CNT_W'(TWR - 1);
          CMD_PRE: begin
            state_q    <= ST_CLOSED;
            row_open_q <= 1'b0;
          end
          CMD_REFRESH: begin
            state_q   <= ST_REFRESHING;
            cnt_q     <= CNT_W'(TRFC - 1);
            refi_q    <= '0;
            overdue_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the array has no reset, so stored words survive rst like a real device's cells.
  always_ff @(posedge clk) begin
    if (accept && cmd == CMD_WRITE) mem_q[addr] <= dq;
  end

  assign rd_data = mem_q[addr];

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (CL)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept && cmd == CMD_READ),
    .data_i (rd_data),
    .vld_o  (rd_vld),
    .data_o (pipe_data)
  );

  assign dq = rd_vld ? pipe_data : {DATA_W{1'bz}};

  assign bus.rd_vld          = rd_vld;
  assign bus.row_open        = row_open_q;
  assign bus.open_row        = open_row_q;
  assign bus.err_vld         = err_vld_q;
  assign bus.err_code        = err_code_q;
  assign bus.refresh_overdue = overdue_q;

endmodule
